fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
Write-side pointer and flag controller for the asynchronous FIFO; the counterpart of the read-side controller. It lives in the write clock domain and owns the binary write pointer, the registered Gray-coded write pointer exported to the read domain, and the write address into the dual-port memory. It compares against the Gray read pointer brought into the write domain to generate full, almost-full and a sticky overflow flag.

Parameters:
W, 8, address width; depth = 2^W entries; pointers are W+1 bits; W >= 2
AF_MARGIN, 2, almost_full asserts when fill level >= 2^W - AF_MARGIN; range 1..2^W-1

Ports:
clk  in  1  write-domain clock
rst  in  1  asynchronous active-low reset
wr_flag  in  1  write request, one entry per cycle while high
ovf_clr  in  1  synchronous clear of overflow
G_RD_PTR  in  W+1  Gray read pointer in the write domain (see Optional Feature)
full  out  1  FIFO full, combinational
almost_full  out  1  fill level >= 2^W - AF_MARGIN, combinational
wr_en  out  1  memory write enable = wr_flag & !full
overflow  out  1  sticky: a write was attempted while full
WR_ADDR  out  W  memory write address = WR_PTR[W-1:0]
WR_PTR  out  W+1  binary write pointer, registered
G_WR_PTR  out  W+1  Gray write pointer, registered, to read-domain synchroniser

Behaviour:
- Clock: single clock clk; reset rst is asynchronous and active-low. On rst low, all registers clear immediately, with no clock required.
- Reset values: WR_PTR=0, G_WR_PTR=0, overflow=0, and any internal synchroniser stages = 0.
- While rst is low: full=0, almost_full=0, wr_en=0, WR_ADDR=0.
- Accept: on posedge clk with wr_en=1, WR_PTR <= WR_PTR+1 (mod 2^(W+1)).
  - On the same edge, G_WR_PTR <= gray(WR_PTR+1), where gray(b) = b ^ (b>>1).
  - G_WR_PTR therefore always equals gray(WR_PTR) and changes by exactly one bit per write.
  - G_WR_PTR must never be driven combinationally.
- Memory write: data is written at WR_ADDR on the same edge the pointer advances. Latency request -> pointer increment = 1 cycle.
- Full: full = (G_WR_PTR == {~Grd[W:W-1], Grd[W-2:0]}), where Grd is the effective Gray read pointer.
  - Full is evaluated on the current registered pointer. No write is accepted while full=1.
- Fill level: level = (WR_PTR - bin(Grd)) mod 2^(W+1), where bin() is Gray-to-binary (prefix XOR from MSB). Range 0..2^W.
  - almost_full = (level >= 2^W - AF_MARGIN).
  - full implies almost_full.
- Overflow:
  - Set on posedge when wr_flag=1 and full=1; the write is dropped and the pointer holds.
  - Cleared on posedge when ovf_clr=1 and no set condition is present; set wins if both occur on the same cycle.
  - Cleared by reset.
- Wrap-around: WR_PTR rolls from 2^(W+1)-1 to 0 with no special handling. The MSB toggles every 2^W writes; Gray wraps 1000..0 -> 0..0 with a single bit change.
- Read pointer movement: a change in Grd may deassert full in the same cycle; no write is lost. Stale Grd is conservative only (it can only overstate fullness).
- Reset mid-operation: pointers drop to 0 asynchronously. The read side must be reset in the same event; this block does not resynchronise.

Optional Feature:
FIFO_WR_SYNC_EN: when defined, the block contains a 2-flop synchroniser on G_RD_PTR (both stages reset to 0), and Grd is the second stage. full and almost_full deassertion then lags a read by 2 clk edges. When undefined, Grd = G_RD_PTR directly; synchronisation is done outside the block and there is no added latency.

Test Plan:
1. Fill. Setup: W=3, AF_MARGIN=2, FIFO_WR_SYNC_EN undefined, G_RD_PTR=0. Stimulus: wr_flag high for 9 cycles. Required response:
   - WR_PTR counts 0..8; almost_full asserts when WR_PTR=6.
   - After the 8th write, full=1, G_WR_PTR=4'b1100.
   - The 9th request gives wr_en=0, WR_PTR stays 8, and overflow=1 on the next edge.
2. Overflow clear. Pulse ovf_clr for one cycle with full held -> overflow=0. Repeat with ovf_clr and wr_flag high together while full -> overflow stays 1.
3. Release. From full (WR_PTR=8), set G_RD_PTR=gray(1)=4'b0001 -> full=0 in the same cycle; the next write gives WR_PTR=9, G_WR_PTR=4'b1101, full=1 again.
4. Wrap. Hold G_RD_PTR equal to gray of a trailing read pointer while writing 40 entries -> WR_PTR passes 15 -> 0. Required: WR_ADDR cycles 0..7 and G_WR_PTR changes exactly one bit per write (bench check). full is never asserted while level < 8.
5. Async reset. Assert rst low mid-burst between clk edges -> WR_PTR, G_WR_PTR and overflow are 0 immediately, full=wr_en=0; on release the first write goes to WR_ADDR=0.
6. Synchroniser latency (FIFO_WR_SYNC_EN defined). From full, change G_RD_PTR to 4'b0001 -> full stays 1 for 2 edges, then drops on the 2nd edge.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer/flag controller for an asynchronous FIFO (write clock domain).
// Define FIFO_WR_SYNC_EN to add an internal 2-flop synchroniser on G_RD_PTR.
module fifo_wr_ctrl #(
    parameter int W         = 8,
    parameter int AF_MARGIN = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_flag,
    input  logic         ovf_clr,
    input  logic [W:0]   G_RD_PTR,
    output logic         full,
    output logic         almost_full,
    output logic         wr_en,
    output logic         overflow,
    output logic [W-1:0] WR_ADDR,
    output logic [W:0]   WR_PTR,
    output logic [W:0]   G_WR_PTR
);

    localparam logic [W:0] AF_THRESH = (W+1)'((1 << W) - AF_MARGIN);

    function automatic logic [W:0] bin_to_gray(input logic [W:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W:0] gray_to_bin(input logic [W:0] g);
        logic [W:0] b;
        b[W] = g[W];
        for (int i = W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [W:0] wr_ptr_q, wr_ptr_d;
    logic [W:0] g_wr_ptr_q, g_wr_ptr_d;
    logic       overflow_q, overflow_d;
    logic [W:0] grd_s;
    logic [W:0] rd_bin_s;
    logic [W:0] level_s;
    logic       full_s;
    logic       af_s;
    logic       wr_en_s;

`ifdef FIFO_WR_SYNC_EN
    logic [W:0] sync1_q, sync2_q;

    // Two-stage synchroniser bringing the read-domain Gray pointer across.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= {(W+1){1'b0}};
            sync2_q <= {(W+1){1'b0}};
        end else begin
            sync1_q <= G_RD_PTR;
            sync2_q <= sync1_q;
        end
    end

    assign grd_s = sync2_q;
`else
    assign grd_s = G_RD_PTR;
`endif

    // Flags, write enable and next-state for pointers and the sticky overflow.
    always_comb begin
        rd_bin_s   = gray_to_bin(grd_s);
        level_s    = wr_ptr_q - rd_bin_s;
        // Full when the Gray pointers differ only in their two top bits.
        full_s     = rst && (g_wr_ptr_q == {~grd_s[W:W-1], grd_s[W-2:0]});
        af_s       = rst && ((level_s >= AF_THRESH) || full_s);
        wr_en_s    = rst && wr_flag && !full_s;
        wr_ptr_d   = wr_ptr_q;
        g_wr_ptr_d = g_wr_ptr_q;
        overflow_d = overflow_q;
        if (wr_en_s) begin
            wr_ptr_d   = wr_ptr_q + {{W{1'b0}}, 1'b1};
            g_wr_ptr_d = bin_to_gray(wr_ptr_d);
        end else begin
            wr_ptr_d   = wr_ptr_q;
            g_wr_ptr_d = g_wr_ptr_q;
        end
        if (wr_flag && full_s) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Pointer and overflow state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= {(W+1){1'b0}};
            g_wr_ptr_q <= {(W+1){1'b0}};
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            g_wr_ptr_q <= g_wr_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign full        = full_s;
    assign almost_full = af_s;
    assign wr_en       = wr_en_s;
    assign overflow    = overflow_q;
    assign WR_ADDR     = wr_ptr_q[W-1:0];
    assign WR_PTR      = wr_ptr_q;
    assign G_WR_PTR    = g_wr_ptr_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Randomised self-checking bench for fifo_wr_ctrl (W=3, AF_MARGIN=2) against a fill-level model.
module tb_fifo_wr_ctrl;

    localparam int W = 3;
    localparam int AFM = 2;
    localparam int DEPTH = 1 << W;
    localparam int PMOD = 2 * DEPTH;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_flag;
    logic         ovf_clr;
    logic [W:0]   G_RD_PTR;
    logic         full, almost_full, wr_en, overflow;
    logic [W-1:0] WR_ADDR;
    logic [W:0]   WR_PTR, G_WR_PTR;

    int total = 0;
    int bad = 0;

    // Reference model: integer write/read counts; read pointer seen with optional lag.
    int m_wp, m_ovf, rd_ptr, s1, s2, m_last_en;

    fifo_wr_ctrl #(.W(W), .AF_MARGIN(AFM)) dut (
        .clk(clk), .rst(rst), .wr_flag(wr_flag), .ovf_clr(ovf_clr),
        .G_RD_PTR(G_RD_PTR), .full(full), .almost_full(almost_full),
        .wr_en(wr_en), .overflow(overflow), .WR_ADDR(WR_ADDR),
        .WR_PTR(WR_PTR), .G_WR_PTR(G_WR_PTR)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] gray(input int b);
        logic [W:0] v;
        v = b[W:0];
        return v ^ (v >> 1);
    endfunction

    function automatic int eff_rp();
`ifdef FIFO_WR_SYNC_EN
        return s2;
`else
        return rd_ptr;
`endif
    endfunction

    function automatic int m_level();
        return (m_wp - eff_rp() + PMOD) % PMOD;
    endfunction

    function automatic logic m_full();
        return m_level() == DEPTH;
    endfunction

    function automatic logic m_af();
        return m_level() >= DEPTH - AFM;
    endfunction

    task automatic model_reset();
        m_wp = 0; m_ovf = 0; rd_ptr = 0; s1 = 0; s2 = 0; m_last_en = 0;
    endtask

    task automatic tick();
        logic f;
        @(posedge clk);
        f = m_full();
        m_last_en = (wr_flag && !f) ? 1 : 0;
        if (wr_flag && f) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        if (m_last_en == 1) m_wp = (m_wp + 1) % PMOD;
        s2 = s1;
        s1 = rd_ptr;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; wr_flag = 1'b1; ovf_clr = 1'b0; G_RD_PTR = gray(3);
        model_reset();
        #2;
        total++; if ({full, almost_full, wr_en, overflow} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {full, almost_full, wr_en, overflow}); end
        total++; if (WR_PTR !== 4'd0 || G_WR_PTR !== 4'd0 || WR_ADDR !== 3'd0) begin
            bad++; $display("FAIL reset_ptrs got=%0d/%0d/%0d want=0/0/0", WR_PTR, G_WR_PTR, WR_ADDR); end
        wr_flag = 1'b0; G_RD_PTR = 4'd0;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        wr_flag = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #1;
            total++; if (WR_PTR !== m_wp[W:0] || full !== m_full() || almost_full !== m_af()
                         || wr_en !== !m_full()) begin
                bad++; $display("FAIL fill_cycle%0d got ptr=%0d f=%b af=%b en=%b want ptr=%0d f=%b af=%b",
                                k, WR_PTR, full, almost_full, wr_en, m_wp, m_full(), m_af()); end
            tick();
        end
        wr_flag = 1'b0;
        #1;
        total++; if (full !== 1'b1 || G_WR_PTR !== 4'b1100 || WR_PTR !== 4'd8) begin
            bad++; $display("FAIL fill_end got f=%b g=%b p=%0d want 1/1100/8", full, G_WR_PTR, WR_PTR); end
        total++; if (overflow !== 1'b1) begin
            bad++; $display("FAIL fill_overflow got=%b want=1", overflow); end
    endtask

    task automatic test_ovf_clear();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        total++; if (overflow !== m_ovf[0] || overflow !== 1'b0) begin
            bad++; $display("FAIL ovf_clr got=%b want=0", overflow); end
        ovf_clr = 1'b1; wr_flag = 1'b1; tick(); ovf_clr = 1'b0; wr_flag = 1'b0;
        total++; if (overflow !== 1'b1 || WR_PTR !== 4'd8) begin
            bad++; $display("FAIL ovf_set_wins got ovf=%b ptr=%0d want 1/8", overflow, WR_PTR); end
    endtask

`ifndef FIFO_WR_SYNC_EN
    task automatic test_release();
        rd_ptr = 1; G_RD_PTR = gray(rd_ptr); wr_flag = 1'b1;
        #1;
        total++; if (full !== 1'b0 || wr_en !== 1'b1) begin
            bad++; $display("FAIL release_same_cycle got f=%b en=%b want 0/1", full, wr_en); end
        tick(); wr_flag = 1'b0; #1;
        total++; if (WR_PTR !== 4'd9 || G_WR_PTR !== 4'b1101 || full !== 1'b1) begin
            bad++; $display("FAIL release_write got p=%0d g=%b f=%b want 9/1101/1", WR_PTR, G_WR_PTR, full); end
    endtask
`else
    task automatic test_sync_latency();
        // precondition: FIFO full with read pointer at 0 (after reset + 8 writes)
        wr_flag = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        wr_flag = 1'b0;
        #1;
        total++; if (full !== 1'b1) begin
            bad++; $display("FAIL sync_prefull got=%b want=1", full); end
        rd_ptr = 1; G_RD_PTR = gray(rd_ptr); #1;
        total++; if (full !== 1'b1) begin
            bad++; $display("FAIL sync_edge0 got=%b want=1", full); end
        tick();
        total++; if (full !== 1'b1) begin
            bad++; $display("FAIL sync_edge1 got=%b want=1", full); end
        tick();
        total++; if (full !== 1'b0 || full !== m_full()) begin
            bad++; $display("FAIL sync_edge2 got=%b want=0", full); end
    endtask
`endif

    task automatic test_wrap_random();
        int writes = 0;
        int cyc = 0;
        logic [W:0] prev_g;
        while (writes < 40 && cyc < 600) begin
            wr_flag = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 7) == 0);
            #1;
            total++; if (WR_ADDR !== m_wp[W-1:0] || WR_PTR !== m_wp[W:0] || G_WR_PTR !== gray(m_wp)
                         || full !== m_full() || almost_full !== m_af() || overflow !== m_ovf[0]
                         || wr_en !== (wr_flag && !m_full())) begin
                bad++; $display("FAIL wrap_c%0d got a=%0d p=%0d g=%b f=%b af=%b o=%b en=%b want p=%0d lvl=%0d o=%0d",
                                cyc, WR_ADDR, WR_PTR, G_WR_PTR, full, almost_full, overflow, wr_en,
                                m_wp, m_level(), m_ovf); end
            prev_g = G_WR_PTR;
            tick();
            if (m_last_en == 1) writes++;
            total++; if ($countones(G_WR_PTR ^ prev_g) != m_last_en) begin
                bad++; $display("FAIL wrap_gray_step got=%0d bits want=%0d", $countones(G_WR_PTR ^ prev_g), m_last_en); end
            if ((m_wp - rd_ptr + PMOD) % PMOD > 0 && $urandom_range(0, 2) != 0) begin
                rd_ptr = (rd_ptr + 1) % PMOD;
                G_RD_PTR = gray(rd_ptr);
            end
            cyc++;
        end
        wr_flag = 1'b0; ovf_clr = 1'b0;
        total++; if (writes < 40) begin
            bad++; $display("FAIL wrap_timeout got=%0d writes want=40", writes); end
    endtask

    task automatic test_async_reset();
        wr_flag = 1'b1;
        tick(); tick(); tick();
        #2;
        rst = 1'b0;
        model_reset();
        G_RD_PTR = 4'd0;
        #1;
        total++; if (WR_PTR !== 4'd0 || G_WR_PTR !== 4'd0 || overflow !== 1'b0) begin
            bad++; $display("FAIL areset_regs got p=%0d g=%b o=%b want 0", WR_PTR, G_WR_PTR, overflow); end
        total++; if (full !== 1'b0 || wr_en !== 1'b0 || almost_full !== 1'b0) begin
            bad++; $display("FAIL areset_flags got f=%b en=%b af=%b want 0", full, wr_en, almost_full); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (wr_en !== 1'b1 || WR_ADDR !== 3'd0) begin
            bad++; $display("FAIL areset_first got en=%b addr=%0d want 1/0", wr_en, WR_ADDR); end
        tick();
        wr_flag = 1'b0;
        total++; if (WR_PTR !== m_wp[W:0] || WR_PTR !== 4'd1) begin
            bad++; $display("FAIL areset_after got p=%0d want 1", WR_PTR); end
        tick();
        rst = 1'b0; #1; rst = 1'b1;
        model_reset();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_ovf_clear();
`ifndef FIFO_WR_SYNC_EN
        test_release();
`endif
        test_wrap_random();
        test_async_reset();
`ifdef FIFO_WR_SYNC_EN
        test_sync_latency();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
